// File: rtl/approx_mul_err_sweep.sv
// Exhaustive error sweep around a 4-in/4-out approximate 2x2 multiplier:
// drives all 16 input vectors, compares each product to a*b and accumulates error statistics.
module approx_mul_err_sweep #(
    parameter int unsigned ET         = 3,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] dut_in,
    input  logic [3:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] max_err,
    output logic [3:0] worst_vec,
    output logic [4:0] err_cnt,
    output logic [7:0] err_sum,
    output logic [1:0] state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] ET_L        = 4'(ET);

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] max_q, max_d;
    logic [3:0] worst_q, worst_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;

    logic [3:0] exact;
    logic [3:0] err;
    logic [3:0] new_max;

    // a = {in1,in0}, b = {in3,in2}; the largest product 3*3 fits in 4 bits.
    always_comb begin
        exact   = {2'b00, vec_q[1:0]} * {2'b00, vec_q[3:2]};
        err     = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
        new_max = (err > max_q) ? err : max_q;
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        max_d    = max_q;
        worst_d  = worst_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WAIT;
                    vec_d    = 4'd0;
                    settle_d = 4'd0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    max_d    = 4'd0;
                    worst_d  = 4'd0;
                    cnt_d    = 5'd0;
                    sum_d    = 8'd0;
                end
            end
            S_WAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                sum_d = sum_q + {4'b0000, err};
                cnt_d = cnt_q + {4'b0000, (err != 4'd0)};
                // Strict compare keeps the earliest vector on ties.
                if (err > max_q) begin
                    max_d   = err;
                    worst_d = vec_q;
                end
                if (vec_q == 4'd15) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (new_max <= ET_L);
                end else begin
                    vec_d   = vec_q + 4'd1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 4'd0;
            settle_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            max_q    <= 4'd0;
            worst_q  <= 4'd0;
            cnt_q    <= 5'd0;
            sum_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            max_q    <= max_d;
            worst_q  <= worst_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
        end
    end

    assign dut_in      = vec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign max_err     = max_q;
    assign worst_vec   = worst_q;
    assign err_cnt     = cnt_q;
    assign err_sum     = sum_q;
    assign state_dbg_o = state_q;

endmodule

// File: doc/approx_mul_err_sweep.md
# approx_mul_err_sweep

Exhaustive error-characterisation stage for the 4-input/4-output approximate 2x2 multiplier netlists. It sits directly around the approximate multiplier: upstream it drives every one of the 16 input vectors into the combinational multiplier, and downstream it samples the 4-bit product. It compares each product against the exact result, accumulates error statistics, and reports pass/fail against the error threshold (ET) the circuit was synthesised for.

## Interface
- `ET`, default 3, maximum allowed absolute error (0..15)
- `SETTLE_CYC`, default 1, cycles `dut_in` is held before `dut_out` is sampled (1..15)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE
- `dut_in`  out  4  vector to the multiplier under test
  - bit0 → in0, …, bit3 → in1..in3 in order
  - a = {in1,in0}, b = {in3,in2}
- `dut_out`  in  4  multiplier product {out3..out0}, out0 = LSB
- `busy`  out  1  high while the sweep runs
- `done`  out  1  high in DONE; statistics are valid
- `pass`  out  1  `max_err <= ET`; valid only when `done` is high
- `max_err`  out  4  largest absolute error seen
- `worst_vec`  out  4  first `dut_in` value that produced `max_err`
- `err_cnt`  out  5  number of vectors with a nonzero error (0..16)
- `err_sum`  out  8  sum of absolute errors (0..240, cannot overflow)

## Operation
- **States:** IDLE, WAIT, SAMPLE, DONE.
- **Reset values:**
  - state = IDLE
  - `dut_in`=0, `busy`=0, `done`=0, `pass`=0
  - `max_err`=0, `worst_vec`=0, `err_cnt`=0, `err_sum`=0
  - settle counter = 0
- **IDLE/DONE + `start`:** next state is WAIT.
  - `dut_in`=0.
  - All statistics are cleared.
  - `done`=0, `busy`=1.
- **WAIT:** holds `dut_in` for `SETTLE_CYC` cycles, then moves to SAMPLE.
- **SAMPLE (one cycle):**
  - exact = a*b, 4-bit unsigned, range 0..9.
  - e = |`dut_out` − exact|, 4-bit.
  - `err_sum` += e.
  - `err_cnt` += (e≠0).
  - If e > `max_err` (strict), then `max_err`=e and `worst_vec`=`dut_in`. Ties keep the earlier vector.
  - If `dut_in`=15, next state is DONE. Otherwise `dut_in`++ and next state is WAIT.
- **DONE:**
  - `busy`=0, `done`=1.
  - `pass` = (`max_err` <= `ET`), registered on entry.
  - Statistics and `dut_in`=15 are held until `start` or `rst`.
- **Ignored inputs:** `start` during WAIT/SAMPLE is ignored; the sweep is not restarted.
- **`rst` mid-sweep:** every output returns to its reset value on the next edge. No partial statistics survive.
- **`rst` and `start` in the same cycle:** `rst` wins, and the block stays in IDLE.

## Timing
- Start pulse at edge 0 → WAIT with `dut_in`=0 and `busy`=1 after edge 0.
- Each vector takes `SETTLE_CYC`+1 cycles. `dut_out` is sampled at the end of SAMPLE, after `dut_in` has been stable for `SETTLE_CYC`+1 cycles.
- Sweep length is 16·(`SETTLE_CYC`+1) cycles. `done` rises on the edge after the last SAMPLE: 32 cycles after the start edge at the default setting.
- Statistics change only on SAMPLE edges. `pass` changes only on DONE entry and on clear.
- `busy` and `done` are never high together. Exactly one of IDLE, busy, or DONE holds at any time.

## Test plan
- **Exact multiplier model** (`dut_out` = a*b): `done` after 32 cycles; `max_err`=0, `err_cnt`=0, `err_sum`=0, `worst_vec`=0, `pass`=1.
- **Stuck-at-zero output** (`dut_out`=0):
  - `max_err`=9, `worst_vec`=15
  - `err_cnt`=9, `err_sum`=36
  - `pass`=0 (ET=3)
- **Constant 15 output:**
  - `max_err`=15, `worst_vec`=0
  - `err_cnt`=16, `err_sum`=204
  - `pass`=0
- **Off-by-one model** (`dut_out` = (a*b+1) mod 16):
  - `max_err`=1, `worst_vec`=0
  - `err_cnt`=16, `err_sum`=16
  - `pass`=1
- **Control boundaries:**
  - `start` pulsed at cycle 5 of a sweep → ignored; results identical to the uninterrupted sweep.
  - `rst` asserted at cycle 10 → all outputs at reset values next cycle; a new `start` gives a clean full sweep.
  - `start` in DONE → statistics cleared and `done`=0 next cycle.
- **`SETTLE_CYC`=3 with the exact model:**
  - `done` after 64 cycles.
  - Each `dut_in` value is held exactly 4 cycles.
  - A bench model that changes `dut_out` only 3 cycles after `dut_in` changes still gives `max_err`=0.
